argmax_top2_scan: RTL and testbench

- Parametrised successor to the classifier output stage.
- Latches a vector of N_CLASS signed class scores and scans it serially, one element per cycle.
- Reports the winning class index, the runner-up index, and the score margin between them.
- Sits between the output-layer cell array and downstream result logic.
- Uses a ready/valid handshake on both sides, so results are never lost under back-pressure.

---
 rtl/argmax_pkg.sv | 22 ++
 rtl/top2_update.sv | 35 +++
 rtl/argmax_top2_scan.sv | 104 ++++++++++
 tb/tb_argmax_top2_scan.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared types and constants for the top-2 argmax scanner.
package argmax_pkg;

  localparam int unsigned DefNClass = 10;
  localparam int unsigned DefDataW  = 26;
  localparam int unsigned MaxDataW  = 64;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // Most-negative two's-complement value of width w, zero-padded; callers truncate to w bits.
  function automatic logic [MaxDataW-1:0] min_score(int unsigned w);
    logic [MaxDataW-1:0] v;
    v        = '0;
    v[w-1]   = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/top2_update.sv
// One scan step: folds a candidate score into the running best/runner-up pair.
module top2_update #(
  parameter int unsigned DataW = 26,
  parameter int unsigned IdxW  = 4
) (
  input  logic signed [DataW-1:0] x_i,
  input  logic        [IdxW-1:0]  ptr_i,
  input  logic signed [DataW-1:0] best_i,
  input  logic        [IdxW-1:0]  best_idx_i,
  input  logic signed [DataW-1:0] second_i,
  input  logic        [IdxW-1:0]  second_idx_i,
  output logic signed [DataW-1:0] best_o,
  output logic        [IdxW-1:0]  best_idx_o,
  output logic signed [DataW-1:0] second_o,
  output logic        [IdxW-1:0]  second_idx_o
);

  // Strict compares: earlier indices keep their rank among equal scores.
  always_comb begin
    best_o       = best_i;
    best_idx_o   = best_idx_i;
    second_o     = second_i;
    second_idx_o = second_idx_i;
    if (x_i > best_i) begin
      second_o     = best_i;
      second_idx_o = best_idx_i;
      best_o       = x_i;
      best_idx_o   = ptr_i;
    end else if (x_i > second_i) begin
      second_o     = x_i;
      second_idx_o = ptr_i;
    end
  end

endmodule

// File: rtl/argmax_top2_scan.sv
// Latches a score vector and scans it serially, reporting winner, runner-up and margin.
module argmax_top2_scan
  import argmax_pkg::*;
#(
  parameter int unsigned N_CLASS = DefNClass,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned IDX_W   = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
  input  logic                      clk,
  input  logic                      GlobalReset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CLASS*DATA_W-1:0] scores,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          top_idx,
  output logic [IDX_W-1:0]          second_idx,
  output logic signed [DATA_W-1:0]  top_score,
  output logic [DATA_W:0]           margin
);

  localparam logic signed [DATA_W-1:0] MinScore = DATA_W'(min_score(DATA_W));
  localparam logic [IDX_W-1:0]         LastIdx  = IDX_W'(N_CLASS - 1);

  state_e                    state_q;
  logic signed [DATA_W-1:0]  arr_q [N_CLASS];
  logic signed [DATA_W-1:0]  best_q, second_q, best_d, second_d;
  logic        [IDX_W-1:0]   best_idx_q, second_idx_q, best_idx_d, second_idx_d;
  logic        [IDX_W-1:0]   ptr_q;
  logic signed [DATA_W:0]    margin_d;

  top2_update #(
    .DataW (DATA_W),
    .IdxW  (IDX_W)
  ) u_update (
    .x_i          (arr_q[ptr_q]),
    .ptr_i        (ptr_q),
    .best_i       (best_q),
    .best_idx_i   (best_idx_q),
    .second_i     (second_q),
    .second_idx_i (second_idx_q),
    .best_o       (best_d),
    .best_idx_o   (best_idx_d),
    .second_o     (second_d),
    .second_idx_o (second_idx_d)
  );

  // One extra bit makes the difference exact across the full signed range.
  assign margin_d = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q      <= StIdle;
      for (int unsigned k = 0; k < N_CLASS; k++) arr_q[k] <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      second_q     <= '0;
      second_idx_q <= '0;
      ptr_q        <= '0;
      top_idx      <= '0;
      second_idx   <= '0;
      top_score    <= '0;
      margin       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < N_CLASS; k++) begin
              arr_q[k] <= scores[k*DATA_W +: DATA_W];
            end
            best_q       <= scores[0 +: DATA_W];
            best_idx_q   <= '0;
            second_q     <= MinScore;
            second_idx_q <= '0;
            ptr_q        <= IDX_W'(1);
            state_q      <= StScan;
          end
        end
        StScan: begin
          best_q       <= best_d;
          best_idx_q   <= best_idx_d;
          second_q     <= second_d;
          second_idx_q <= second_idx_d;
          ptr_q        <= ptr_q + 1'b1;
          if (ptr_q == LastIdx) begin
            top_idx    <= best_idx_d;
            second_idx <= second_idx_d;
            top_score  <= best_d;
            margin     <= margin_d;
            state_q    <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_top2_scan.sv
// Randomised self-checking bench for argmax_top2_scan against a sort-style reference model.
module tb_argmax_top2_scan;

  localparam int N  = 10;
  localparam int W  = 26;
  localparam int IW = 4;
  localparam longint SMin = -33554432;
  localparam longint SMax = 33554431;

  logic              clk = 1'b0;
  logic              GlobalReset;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0]    scores;
  logic [IW-1:0]     top_idx, second_idx;
  logic [W-1:0]      top_score;
  logic [W:0]        margin;

  int     errors = 0;
  int     checks = 0;
  longint vec  [N];
  longint vec2 [N];
  longint e_ti, e_si, e_top, e_margin;

  argmax_top2_scan #(
    .N_CLASS (N),
    .DATA_W  (W)
  ) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .scores      (scores),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .top_idx     (top_idx),
    .second_idx  (second_idx),
    .top_score   (top_score),
    .margin      (margin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*W-1:0] pack(input longint v [N]);
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'(v[k]);
    return f;
  endfunction

  // Winner is the first index holding the maximum; runner-up is the first other index holding
  // the largest remaining value. The runner-up slot starts as a most-negative sentinel at
  // index 0, so when the winner is class 0 and everything else is most-negative, it stays 0.
  task automatic model(input longint v [N]);
    int ti, si;
    ti = 0;
    for (int k = 1; k < N; k++) if (v[k] > v[ti]) ti = k;
    si = -1;
    for (int k = 0; k < N; k++) begin
      if (k != ti && (si < 0 || v[k] > v[si])) si = k;
    end
    e_ti     = ti;
    e_top    = v[ti];
    e_margin = v[ti] - v[si];
    if (ti == 0 && v[si] == SMin) si = 0;
    e_si     = si;
  endtask

  task automatic check_result(input string tag);
    check({tag, ":top_idx"},    longint'(top_idx), e_ti);
    check({tag, ":second_idx"}, longint'(second_idx), e_si);
    check({tag, ":top_score"},  longint'($signed(top_score)), e_top);
    check({tag, ":margin"},     longint'(margin), e_margin);
  endtask

  // Sends vec, checks latency and result, holds back-pressure for 'hold' cycles, then hands off.
  // With 'pend' set, vec2 is offered on in_valid during the hold and left asserted afterwards.
  task automatic run_vec(input string tag, input int hold, input bit pend);
    int n;
    model(vec);
    scores   = pack(vec);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, ":in_ready_before_accept"}, longint'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) scores[k*W +: W] = W'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, ":latency"}, n, N - 1);
    check_result(tag);
    if (pend) begin
      scores   = pack(vec2);
      in_valid = 1'b1;
    end
    for (int c = 0; c < hold; c++) begin
      tick();
      check({tag, ":hold_out_valid"}, longint'(out_valid), 1);
      check({tag, ":hold_in_ready"},  longint'(in_ready), 0);
      check_result({tag, ":hold"});
    end
    out_ready = 1'b1;
    check({tag, ":handoff_in_ready"}, longint'(in_ready), 0);
    tick();
    out_ready = 1'b0;
    check({tag, ":post_out_valid"}, longint'(out_valid), 0);
    check({tag, ":post_in_ready"},  longint'(in_ready), 1);
  endtask

  function automatic longint rand_score();
    case ($urandom_range(0, 5))
      0:       return SMin;
      1:       return SMax;
      2, 3:    return longint'($urandom_range(0, 8)) - 4;
      default: return longint'($urandom_range(0, 67108863)) - 33554432;
    endcase
  endfunction

  initial begin
    bit saw_valid;
    GlobalReset = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    scores      = '0;
    #12;
    check("reset:in_ready",  longint'(in_ready), 1);
    check("reset:out_valid", longint'(out_valid), 0);
    check("reset:top_idx",   longint'(top_idx), 0);
    check("reset:margin",    longint'(margin), 0);
    @(negedge clk);
    GlobalReset = 1'b1;
    tick();

    for (int k = 0; k < N; k++) vec[k] = k * 100;
    run_vec("basic", 2, 1'b0);
    check("basic:abs_top", longint'($signed(top_score)), 900);

    vec[0] = -50; vec[1] = -3; vec[2] = -7; vec[3] = -100;
    for (int k = 4; k < N; k++) vec[k] = -200;
    run_vec("allneg", 0, 1'b0);

    for (int k = 0; k < N; k++) vec[k] = 0;
    vec[2] = 500; vec[6] = 500;
    run_vec("ties", 1, 1'b0);

    for (int k = 0; k < N; k++) vec[k] = SMin;
    vec[0] = SMax;
    run_vec("extremes", 0, 1'b0);

    // Back-pressure with a second vector waiting; it must be taken only after handoff.
    for (int k = 0; k < N; k++) vec[k] = k * 100;
    for (int k = 0; k < N; k++) vec2[k] = (k == 4) ? 77 : -k;
    run_vec("bp", 20, 1'b1);
    vec = vec2;
    run_vec("bp_second", 0, 1'b0);

    // Asynchronous reset four cycles into a scan.
    for (int k = 0; k < N; k++) vec[k] = 1000 - k;
    scores   = pack(vec);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2;
    GlobalReset = 1'b0;
    #1;
    check("rst_mid:in_ready",   longint'(in_ready), 1);
    check("rst_mid:out_valid",  longint'(out_valid), 0);
    check("rst_mid:top_idx",    longint'(top_idx), 0);
    check("rst_mid:second_idx", longint'(second_idx), 0);
    check("rst_mid:top_score",  longint'(top_score), 0);
    check("rst_mid:margin",     longint'(margin), 0);
    @(negedge clk);
    GlobalReset = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      saw_valid = saw_valid | out_valid;
    end
    check("rst_mid:no_out_valid", longint'(saw_valid), 0);
    for (int k = 0; k < N; k++) vec[k] = (k == 7) ? 12345 : k * 3;
    run_vec("after_rst", 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < N; k++) vec[k] = rand_score();
      run_vec($sformatf("rand%0d", t), $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
